// File: rtl/noc_pkg.sv
// Shared NoC router types: flit layout, port count and small helpers.
// Flit type lives in the two MSBs of every flit.
package noc_pkg;

    localparam int FLIT_W = 34;
    localparam int NPORTS = 4;

    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_e;

    function automatic flit_type_e flit_type(input logic [1:0] tbits);
        return flit_type_e'(tbits);
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Output-port flit FIFO; power-of-two depth so pointers wrap naturally.
// Full and empty come from the registered count only.
module noc_flit_fifo #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 34
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [FLIT_W-1:0]      din,
    output logic [FLIT_W-1:0]      dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    import noc_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [CW-1:0]     r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wr <= r_wr + 1'b1;
            if (pop)  r_rd <= r_rd + 1'b1;
            unique case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr] <= din;
    end

    assign dout  = r_mem[r_rd];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/noc_out_port.sv
// NoC router output port: grant-selected input mux, packet lock FSM,
// protocol-error pulse and output flit FIFO toward the link.
module noc_out_port #(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        in_valid,
    input  logic [4*FLIT_W-1:0] in_flit,
    output logic [3:0]        in_ready,
    input  logic [3:0]        grant,
    output logic              lock,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    input  logic              out_ready,
    output logic              err
);
    import noc_pkg::*;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    logic [0:0]              r_state;
    logic [3:0]              r_sel_q;
    logic                    r_err;

    logic [0:0]              w_next;
    logic [3:0]              w_sel;
    logic [FLIT_W-1:0]       w_flit;
    flit_type_e              w_type;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_err_set;
    logic                    w_full;
    logic                    w_empty;
    logic [$clog2(DEPTH):0]  w_count;
    logic                    w_unused;

    // In XFER the packet's channel is pinned; the arbiter's grant is ignored.
    assign w_sel = (r_state == S_XFER) ? r_sel_q
                 : (is_onehot4(grant) ? grant : 4'b0000);

    assign in_ready = w_sel & {4{~w_full}};
    assign w_accept = |(in_valid & in_ready);

    always_comb begin
        w_flit = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (w_sel[i]) w_flit = in_flit[i*FLIT_W +: FLIT_W];
        end
    end

    assign w_type = flit_type(w_flit[FLIT_W-1:FLIT_W-2]);

    always_comb begin
        w_next    = r_state;
        w_push    = 1'b0;
        w_err_set = 1'b0;
        if (w_accept) begin
            unique case (r_state)
                S_IDLE: begin
                    unique case (w_type)
                        HEAD: begin
                            w_push = 1'b1;
                            w_next = S_XFER;
                        end
                        SINGLE:  w_push    = 1'b1;
                        default: w_err_set = 1'b1;
                    endcase
                end
                default: begin
                    w_push = 1'b1;
                    unique case (w_type)
                        TAIL:    w_next    = S_IDLE;
                        BODY:    w_next    = S_XFER;
                        default: w_err_set = 1'b1;
                    endcase
                end
            endcase
        end
    end

    // Combinational so the arbiter sees it in the head-accept cycle.
    assign lock = ((r_state == S_XFER) && !(w_accept && w_type == TAIL))
               || ((r_state == S_IDLE) && w_accept && w_type == HEAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sel_q <= 4'b0000;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_set;
            if (r_state == S_IDLE && w_next == S_XFER) r_sel_q <= w_sel;
        end
    end

    assign err       = r_err;
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign w_unused  = ^w_count;

    noc_flit_fifo #(
        .DEPTH  (DEPTH),
        .FLIT_W (FLIT_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (w_push),
        .pop    (w_pop),
        .din    (w_flit),
        .dout   (out_flit),
        .count  (w_count),
        .full   (w_full),
        .empty  (w_empty)
    );

endmodule
